// File: rtl/cdm_pkg.sv
// Shared definitions for the carry-disregard multiplier accumulation path.
package cdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;

endpackage

// File: rtl/cdm_acc_add.sv
// Accumulator adder with carry-out; wraps by default, clamps when ACC_SATURATE_EN is defined.
module cdm_acc_add
  import cdm_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum_out,
  output logic              carry_out
);

  logic [ACC_W:0] full_sum;

  assign full_sum  = {1'b0, acc_in} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign carry_out = full_sum[ACC_W];

`ifdef ACC_SATURATE_EN
  // A clamped all-ones accumulator carries again on any nonzero beat, so it stays clamped.
  assign sum_out = carry_out ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum_out = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/cdm8_acc_stage.sv
// Dot-product accumulation stage for the 8x8 approximate multiplier's products.
// Optional macro ACC_SATURATE_EN selects clamping instead of wrapping on overflow.
module cdm8_acc_stage
  import cdm_pkg::*;
#(
  parameter  int ACC_W = ACC_W_DEF,
  parameter  int LEN   = 16,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [PROD_W-1:0] p_data,
  input  logic              p_last,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf
);

  acc_state_t       state;
  logic             beat;
  logic [CNT_W-1:0] next_count;
  logic             close_by_len;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  assign p_ready      = (state != DONE);
  assign acc_valid    = (state == DONE);
  assign beat         = p_valid && p_ready;
  assign next_count   = acc_count + 1'b1;
  assign close_by_len = (next_count == CNT_W'(LEN));

  cdm_acc_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .acc_in   (acc_data),
    .prod     (p_data),
    .sum_out  (add_sum),
    .carry_out(add_carry)
  );

  // The first beat of a vector loads rather than adds, so IDLE never needs a clearing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_data  <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            acc_data  <= {{(ACC_W - PROD_W){1'b0}}, p_data};
            acc_count <= CNT_W'(1);
            acc_ovf   <= 1'b0;
            state     <= p_last ? DONE : ACC;
          end
        end
        ACC: begin
          if (beat) begin
            acc_data  <= add_sum;
            acc_count <= next_count;
            acc_ovf   <= acc_ovf | add_carry;
            if (p_last || close_by_len) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            state     <= IDLE;
            acc_data  <= '0;
            acc_count <= '0;
            acc_ovf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdm8_acc_stage.sv
// Scoreboard bench for cdm8_acc_stage: a 24-bit default instance plus a 17-bit overflow instance.
module tb_cdm8_acc_stage;

  localparam int W   = 24;
  localparam int LEN = 16;
  localparam int CW  = $clog2(LEN + 1);
  localparam int WB  = 17;

  typedef struct {
    logic [31:0] data;
    int          count;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic          p_valid, p_ready, p_last, acc_valid, acc_ready, acc_ovf;
  logic [15:0]   p_data;
  logic [W-1:0]  acc_data;
  logic [CW-1:0] acc_count;

  logic          b_p_valid, b_p_ready, b_p_last, b_acc_valid, b_acc_ready, b_acc_ovf;
  logic [15:0]   b_p_data;
  logic [WB-1:0] b_acc_data;
  logic [CW-1:0] b_acc_count;

  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];
  longint m_sum = 0;
  int     m_cnt = 0;

  always #5 clk = ~clk;

  cdm8_acc_stage #(.ACC_W(W), .LEN(LEN)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data), .p_last(p_last),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .acc_count(acc_count), .acc_ovf(acc_ovf)
  );

  cdm8_acc_stage #(.ACC_W(WB), .LEN(LEN)) dut17 (
    .clk(clk), .rst(rst),
    .p_valid(b_p_valid), .p_ready(b_p_ready), .p_data(b_p_data), .p_last(b_p_last),
    .acc_valid(b_acc_valid), .acc_ready(b_acc_ready), .acc_data(b_acc_data),
    .acc_count(b_acc_count), .acc_ovf(b_acc_ovf)
  );

  // Reference model: exact sum, reduced to the result width only when a vector closes.
  task automatic model_beat(input logic [15:0] d, input logic l);
    exp_t   e;
    longint maxv;
    maxv  = (longint'(1) << W) - 1;
    m_sum = m_sum + longint'(d);
    m_cnt = m_cnt + 1;
    if (l || m_cnt == LEN) begin
`ifdef ACC_SATURATE_EN
      e.data = (m_sum > maxv) ? 32'(maxv) : 32'(m_sum);
`else
      e.data = 32'(m_sum & maxv);
`endif
      e.count = m_cnt;
      e.ovf   = (m_sum > maxv);
      sb.push_back(e);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int guard = 0;
    p_valid = 1'b1;
    p_data  = d;
    p_last  = l;
    while (!p_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!p_ready) begin
      checks++; errors++;
      $display("[TB] FAIL beat_accept: p_ready=%0b, required 1 within 50 cycles", p_ready);
    end
    @(posedge clk); #1;
    p_valid = 1'b0;
    p_last  = 1'b0;
    model_beat(d, l);
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   guard = 0;
    while (!acc_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (!acc_valid) begin
      errors++;
      $display("[TB] FAIL %s_timeout: acc_valid=%0b, required 1", name, acc_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_unexpected: result with empty scoreboard, data=%0h", name, acc_data);
    end else begin
      e = sb.pop_front();
      if (acc_data !== W'(e.data)) begin
        errors++;
        $display("[TB] FAIL %s_data: got %0h, expected %0h", name, acc_data, W'(e.data));
      end
      checks++;
      if (acc_count !== CW'(e.count)) begin
        errors++;
        $display("[TB] FAIL %s_count: got %0d, expected %0d", name, acc_count, e.count);
      end
      checks++;
      if (acc_ovf !== e.ovf) begin
        errors++;
        $display("[TB] FAIL %s_ovf: got %0b, expected %0b", name, acc_ovf, e.ovf);
      end
    end
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    checks++;
    if (acc_valid !== 1'b0 || p_ready !== 1'b1 || acc_data !== '0) begin
      errors++;
      $display("[TB] FAIL %s_release: valid=%0b ready=%0b data=%0h, expected 0 1 0",
               name, acc_valid, p_ready, acc_data);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (p_ready !== 1'b1 || acc_valid !== 1'b0 || acc_data !== '0 ||
        acc_count !== '0 || acc_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: ready=%0b valid=%0b data=%0h count=%0d ovf=%0b, expected 1 0 0 0 0",
               name, p_ready, acc_valid, acc_data, acc_count, acc_ovf);
    end
  endtask

  task automatic test_reset();
    check_idle_outputs("reset_state");
    send_beat(16'd10, 1'b0);
    send_beat(16'd20, 1'b0);
    send_beat(16'd30, 1'b0);
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_async");
    @(posedge clk); #1;
    rst   = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    check_idle_outputs("reset_mid_vector");
    send_beat(16'd5, 1'b0);
    send_beat(16'd6, 1'b1);
    collect("after_reset");
  endtask

  task automatic test_basic();
    acc_ready = 1'b1;
    send_beat(16'd100, 1'b0);
    send_beat(16'd200, 1'b0);
    checks++;
    if (acc_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_early_valid: got %0b, expected 0", acc_valid);
    end
    send_beat(16'd300, 1'b1);
    checks++;
    if (acc_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_latency: acc_valid=%0b one cycle after last, expected 1", acc_valid);
    end
    collect("basic");
  endtask

  task automatic test_autoclose();
    for (int i = 0; i < LEN; i++) begin
      send_beat(16'hFFFF, 1'b0);
    end
    checks++;
    if (acc_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL autoclose_valid: got %0b, expected 1", acc_valid);
    end
    collect("autoclose");
  endtask

  task automatic test_overflow();
    logic [15:0]   vals [3];
    logic [WB-1:0] exp_data;
    int            guard;
    vals = '{16'hFFFF, 16'hFFFF, 16'h0002};
`ifdef ACC_SATURATE_EN
    exp_data = 17'h1FFFF;
`else
    exp_data = 17'h00000;
`endif
    for (int i = 0; i < 3; i++) begin
      b_p_valid = 1'b1;
      b_p_data  = vals[i];
      b_p_last  = (i == 2);
      guard     = 0;
      while (!b_p_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      @(posedge clk); #1;
    end
    b_p_valid = 1'b0;
    b_p_last  = 1'b0;
    checks++;
    if (b_acc_valid !== 1'b1 || b_acc_data !== exp_data || b_acc_count !== CW'(3) || b_acc_ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow17: valid=%0b data=%0h count=%0d ovf=%0b, expected 1 %0h 3 1",
               b_acc_valid, b_acc_data, b_acc_count, b_acc_ovf, exp_data);
    end
    b_acc_ready = 1'b1;
    @(posedge clk); #1;
    b_acc_ready = 1'b0;
    checks++;
    if (b_acc_valid !== 1'b0 || b_acc_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow17_clear: valid=%0b ovf=%0b, expected 0 0", b_acc_valid, b_acc_ovf);
    end
  endtask

  task automatic test_backpressure();
    send_beat(16'd7, 1'b0);
    send_beat(16'd8, 1'b1);
    p_valid = 1'b1;
    p_data  = 16'h0055;
    p_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (p_ready !== 1'b0 || acc_valid !== 1'b1 || acc_data !== W'(15) || acc_count !== CW'(2)) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: ready=%0b valid=%0b data=%0h count=%0d, expected 0 1 f 2",
                 i, p_ready, acc_valid, acc_data, acc_count);
      end
    end
    p_valid = 1'b0;
    p_last  = 1'b0;
    collect("hold");
    send_beat(16'd9, 1'b1);
    collect("after_hold");
  endtask

  task automatic test_single();
    send_beat(16'h1234, 1'b1);
    checks++;
    if (acc_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_latency: acc_valid=%0b, expected 1", acc_valid);
    end
    collect("single");
  endtask

  task automatic test_back_to_back();
    send_beat(16'd1, 1'b0);
    send_beat(16'd2, 1'b1);
    collect("b2b_first");
    send_beat(16'd40, 1'b1);
    collect("b2b_second");
  endtask

  initial begin
    rst         = 1'b1;
    p_valid     = 1'b0;
    p_data      = '0;
    p_last      = 1'b0;
    acc_ready   = 1'b0;
    b_p_valid   = 1'b0;
    b_p_data    = '0;
    b_p_last    = 1'b0;
    b_acc_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    test_reset();
    test_basic();
    test_autoclose();
    test_overflow();
    test_backpressure();
    test_single();
    test_back_to_back();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
